// File: rtl/router_pkg.sv
// Shared router constants: default buffer geometry and header field layout.
// The header word carries the destination in its low bits and the payload
// length (excluding the trailing parity byte) just above it.
package router_pkg;

  // Default buffer geometry for one destination port.
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Payload-length field inside the header word.
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_LEN_W   = 6;

  // Destination field inside the header word, shared with the router FSM.
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_W   = 2;
  localparam int NUM_DEST     = 3;

  // Destination encodings; DEST_INV is never routed.
  typedef enum logic [HDR_DEST_W-1:0] {
    DEST_0   = 2'd0,
    DEST_1   = 2'd1,
    DEST_2   = 2'd2,
    DEST_INV = 2'd3
  } dest_e;

  // Extract the destination field from the low byte of a header word.
  function automatic dest_e hdr_dest(input logic [7:0] hdr);
    return dest_e'(hdr[HDR_DEST_LSB +: HDR_DEST_W]);
  endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read bus of one router output-channel buffer.
//
// Handshake: the producer may assert write_enb with data_in/lfd_state in any
// cycle; the word is taken on the rising edge only when the buffer is not
// full, otherwise it is dropped and must be re-offered. read_enb pops one word
// on the rising edge only when the buffer is not empty; the popped word is
// presented on data_out with out_valid=1 for exactly the following cycle,
// together with its sop_out/eop_out sideband. There is no back-pressure on
// the read side: the consumer owns the popped word as soon as out_valid is 1.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              sop_out;
  logic              eop_out;

  // Producer/consumer side (router FSM and port reader).
  modport master (
    output write_enb,
    output lfd_state,
    output data_in,
    output read_enb,
    input  data_out,
    input  out_valid,
    input  sop_out,
    input  eop_out
  );

  // Buffer side.
  modport slave (
    input  write_enb,
    input  lfd_state,
    input  data_in,
    input  read_enb,
    output data_out,
    output out_valid,
    output sop_out,
    output eop_out
  );

endinterface

// File: rtl/router_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port. Contents are not reset; the pointers decide what is valid.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word at the write address.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel buffer. Each stored word carries a start-of-
// packet tag; on the read side the header length is used to mark the parity
// byte with eop_out and to flag framing errors.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LEN_LSB   = HDR_LEN_LSB,
  parameter int LEN_W     = HDR_LEN_W,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                soft_reset,
  router_pkt_fifo_if.slave    bus,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic [ADDR_W:0]     fill_level,
  output logic                pkt_err
);

  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [LEN_W:0]  REM_ONE = (LEN_W+1)'(1);

  // Pointers carry one extra MSB that toggles on every wrap.
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q,   fill_d;
  // Words still owed by the packet currently being read, parity included.
  logic [LEN_W:0]    pkt_rem_q, pkt_rem_d;

  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              valid_q, valid_d;
  logic              sop_q,   sop_d;
  logic              eop_q,   eop_d;
  logic              err_q,   err_d;

  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic [DATA_W:0]   rd_word;
  logic              rd_tag;
  logic [LEN_W-1:0]  rd_len;

  // Status derived purely from registered pointers and occupancy.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign almost_full = (fill_q >= AF_LVL);
  assign fill_level  = fill_q;
  assign pkt_err     = err_q;

  // A write while full and a read while empty are silently ignored.
  assign wr_acc = bus.write_enb && !full;
  assign rd_acc = bus.read_enb  && !empty;

  // Any reset cycle discards a coincident write so storage stays untouched.
  assign mem_we = wr_acc && resetn && !soft_reset;

  router_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i ({bus.lfd_state, bus.data_in}),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_word)
  );

  assign rd_tag = rd_word[DATA_W];
  assign rd_len = rd_word[LEN_LSB +: LEN_W];

  // Next-state: pointer/occupancy update, popped-word sideband and framing.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    pkt_rem_d = pkt_rem_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    err_d     = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = rd_word[DATA_W-1:0];
      valid_d  = 1'b1;
      sop_d    = rd_tag;
      if (rd_tag) begin
        // New header: a previous packet still owing words is a framing error,
        // but the new header always wins.
        err_d     = (pkt_rem_q != '0);
        pkt_rem_d = {1'b0, rd_len} + REM_ONE;
      end else if (pkt_rem_q == '0) begin
        // Body word with no open packet: flag it and stay idle.
        err_d = 1'b1;
      end else begin
        pkt_rem_d = pkt_rem_q - REM_ONE;
        eop_d     = (pkt_rem_q == REM_ONE);
      end
    end

    case ({wr_acc, rd_acc})
      2'b10:   fill_d = fill_q + PTR_ONE;
      2'b01:   fill_d = fill_q - PTR_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // State register; hard and soft reset clear everything except storage,
  // with the hard reset taking precedence (both have the same effect).
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      pkt_rem_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      pkt_rem_q <= pkt_rem_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;

endmodule
